// File: rtl/iob_plic_gateway_pkg.sv
// Shared types and sizing helpers for the PLIC interrupt gateway array.
package iob_plic_gateway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } gw_state_e;

  // Register blocks; block b starts at byte offset b * 4 * W.
  typedef enum logic [2:0] {
    BLK_EL  = 3'd0,
    BLK_POL = 3'd1,
    BLK_EN  = 3'd2,
    BLK_IP  = 3'd3,
    BLK_OVF = 3'd4
  } reg_blk_e;

  localparam int NUM_BLKS = 5;

  function automatic int words_per_blk(input int sources);
    return (sources + 31) / 32;
  endfunction

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/iob_plic_gateway_cell.sv
// One interrupt gateway: synchroniser, polarity, edge capture counter and
// the claim/complete state machine. The FSM state is exported for observation.
module iob_plic_gateway_cell
  import iob_plic_gateway_pkg::*;
#(
  parameter int MAX_PENDING_COUNT = 8,
  parameter int SYNC_STAGES       = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      src,
  input  logic      el,
  input  logic      pol,
  input  logic      en,
  input  logic      el_chg,
  input  logic      claim,
  input  logic      complete,
  output logic      ovf_set,
  output gw_state_e state
);

  localparam int CNT_W = cnt_width(MAX_PENDING_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

  logic             s, a, prev_q, pol_q, rise, edge_ev, claim_take, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gw_state_e        state_q, state_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A polarity flip inverts 'a' without any real source activity, so the
  // edge detector is muted for the cycle after POL changes.
  assign a          = s ^ pol;
  assign rise       = a & ~prev_q & (pol == pol_q);
  assign edge_ev    = el & en & rise;
  assign claim_take = (state_q == ST_PENDING) & claim & ~el_chg;
  assign dec        = claim_take & el & (cnt_q != '0);

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (el_chg) begin
      cnt_d = '0;
    end else if (edge_ev && !dec) begin
      if (cnt_q == CNT_MAX) ovf_set = 1'b1;
      else                  cnt_d   = cnt_q + 1'b1;
    end else if (dec && !edge_ev) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!el_chg && (el ? (cnt_q != '0) : (a && en))) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (el_chg)     state_d = ST_IDLE;
        else if (claim) state_d = ST_CLAIMED;
      end
      ST_CLAIMED: begin
        if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      pol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= a;
      pol_q   <= pol;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/iob_plic_gateway.sv
// Interrupt gateway array with its IOb-bus configuration register file.
// Handshake: every cycle with valid=1 is an accepted request; ready pulses
// exactly one cycle later with rdata (zero for writes and when ready=0).
module iob_plic_gateway
  import iob_plic_gateway_pkg::*;
#(
  parameter int ADDR_W            = 16,
  parameter int DATA_W            = 32,
  parameter int SOURCES           = 64,
  parameter int MAX_PENDING_COUNT = 8,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [SOURCES-1:0]  src,
  output logic [SOURCES-1:0]  ip,
  input  logic [SOURCES-1:0]  claim,
  input  logic [SOURCES-1:0]  complete
);

  localparam int W  = words_per_blk(SOURCES);
  localparam int NB = W * 32;
  localparam int AW = ADDR_W - 2;
  localparam logic [AW-1:0] W_A    = AW'(W);
  localparam logic [AW-1:0] NBLK_A = AW'(NUM_BLKS);

  logic [NB-1:0]      el_q, pol_q, en_q, ovf_q;
  logic [NB-1:0]      el_d, pol_d, en_d, ovf_clr, ovf_set_pad, ip_pad, src_mask;
  logic [SOURCES-1:0] ovf_set, el_chg;
  logic [AW-1:0]      word_idx, blk, widx;
  logic               wr, mapped, unused_addr_lsb;
  logic [DATA_W-1:0]  rd_word, rdata_q;
  logic               ready_q;
  gw_state_e          gw_state [SOURCES];

  assign word_idx        = address[ADDR_W-1:2];
  assign blk             = word_idx / W_A;
  assign widx            = word_idx - blk * W_A;
  assign wr              = |wstrb;
  assign mapped          = blk < NBLK_A;
  assign unused_addr_lsb = ^address[1:0];

  always_comb begin
    src_mask              = '0;
    src_mask[SOURCES-1:0] = '1;
    ip_pad                = '0;
    ip_pad[SOURCES-1:0]   = ip;
    ovf_set_pad           = '0;
    ovf_set_pad[SOURCES-1:0] = ovf_set;
  end

  // Byte-strobed writes; OVF bytes become a write-1-to-clear mask.
  always_comb begin
    el_d    = el_q;
    pol_d   = pol_q;
    en_d    = en_q;
    ovf_clr = '0;
    if (valid && wr && mapped) begin
      for (int k = 0; k < W; k++) begin
        if (widx == AW'(k)) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b]) begin
              case (blk)
                AW'(BLK_EL):  el_d[k*32+b*8 +: 8]    = wdata[b*8 +: 8];
                AW'(BLK_POL): pol_d[k*32+b*8 +: 8]   = wdata[b*8 +: 8];
                AW'(BLK_EN):  en_d[k*32+b*8 +: 8]    = wdata[b*8 +: 8];
                AW'(BLK_OVF): ovf_clr[k*32+b*8 +: 8] = wdata[b*8 +: 8];
                default: ;
              endcase
            end
          end
        end
      end
    end
    el_d  = el_d & src_mask;
    pol_d = pol_d & src_mask;
    en_d  = en_d & src_mask;
  end

  assign el_chg = el_d[SOURCES-1:0] ^ el_q[SOURCES-1:0];

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < W; k++) begin
      if (widx == AW'(k)) begin
        case (blk)
          AW'(BLK_EL):  rd_word = el_q[k*32 +: DATA_W];
          AW'(BLK_POL): rd_word = pol_q[k*32 +: DATA_W];
          AW'(BLK_EN):  rd_word = en_q[k*32 +: DATA_W];
          AW'(BLK_IP):  rd_word = ip_pad[k*32 +: DATA_W];
          AW'(BLK_OVF): rd_word = ovf_q[k*32 +: DATA_W];
          default:      rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      el_q    <= '0;
      pol_q   <= '0;
      en_q    <= '0;
      ovf_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      el_q    <= el_d;
      pol_q   <= pol_d;
      en_q    <= en_d;
      ovf_q   <= (ovf_q & ~ovf_clr) | ovf_set_pad;
      ready_q <= valid;
      rdata_q <= (valid && !wr) ? rd_word : '0;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

  for (genvar i = 0; i < SOURCES; i++) begin : g_cell
    iob_plic_gateway_cell #(
      .MAX_PENDING_COUNT(MAX_PENDING_COUNT),
      .SYNC_STAGES      (SYNC_STAGES)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .src     (src[i]),
      .el      (el_q[i]),
      .pol     (pol_q[i]),
      .en      (en_q[i]),
      .el_chg  (el_chg[i]),
      .claim   (claim[i]),
      .complete(complete[i]),
      .ovf_set (ovf_set[i]),
      .state   (gw_state[i])
    );
  end

  always_comb begin
    for (int i = 0; i < SOURCES; i++) ip[i] = (gw_state[i] == ST_PENDING);
  end

endmodule

// File: tb/tb_iob_plic_gateway.sv
// Bench for iob_plic_gateway: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the gateway rules.
module tb_iob_plic_gateway;

  localparam int SRC  = 64;
  localparam int MAXC = 8;
  localparam int SYNC = 2;
  localparam int W    = 2;
  localparam int M_IDLE = 0, M_PEND = 1, M_CLMD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [63:0] src, ip, claim, complete;

  int n_vec = 0;
  int n_miscmp = 0;

  iob_plic_gateway #(
    .ADDR_W(16), .DATA_W(32), .SOURCES(SRC),
    .MAX_PENDING_COUNT(MAXC), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .src(src), .ip(ip),
    .claim(claim), .complete(complete)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] m_el, m_pol, m_pol_prev, m_en, m_ovf, m_prev;
  logic [63:0] m_pipe [SYNC];
  int          m_cnt [SRC];
  int          m_st  [SRC];
  logic        m_ready;
  logic [31:0] m_rdata;

  function automatic logic [63:0] m_ip();
    logic [63:0] r;
    for (int i = 0; i < SRC; i++) r[i] = (m_st[i] == M_PEND);
    return r;
  endfunction

  always @(posedge clk) begin : m_upd
    logic [63:0] s_v, a_v, el_n, pol_n, en_n, clr, chg, set_v, bm, bv;
    int word, blk, widx, old_cnt, delta;
    logic [31:0] rd;
    logic edge_ev, take, dec;
    if (!rst) begin
      m_el = '0; m_pol = '0; m_pol_prev = '0; m_en = '0; m_ovf = '0; m_prev = '0;
      for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
      for (int i = 0; i < SRC; i++) begin m_cnt[i] = 0; m_st[i] = M_IDLE; end
      m_ready = 1'b0; m_rdata = '0;
    end else begin
      s_v = m_pipe[SYNC-1];
      a_v = s_v ^ m_pol;
      el_n = m_el; pol_n = m_pol; en_n = m_en; clr = '0; set_v = '0; rd = '0;
      word = int'(address >> 2); blk = word / W; widx = word % W;
      if (valid && blk < 5) begin
        if (wstrb == 4'h0) begin
          case (blk)
            0: rd = 32'(m_el  >> (widx*32));
            1: rd = 32'(m_pol >> (widx*32));
            2: rd = 32'(m_en  >> (widx*32));
            3: rd = 32'(m_ip() >> (widx*32));
            default: rd = 32'(m_ovf >> (widx*32));
          endcase
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
              bm = 64'hFF << (widx*32 + b*8);
              bv = 64'(8'(wdata >> (b*8))) << (widx*32 + b*8);
              case (blk)
                0: el_n  = (el_n  & ~bm) | bv;
                1: pol_n = (pol_n & ~bm) | bv;
                2: en_n  = (en_n  & ~bm) | bv;
                4: clr   = clr | bv;
                default: ;
              endcase
            end
          end
        end
      end
      chg = el_n ^ m_el;
      for (int i = 0; i < SRC; i++) begin
        edge_ev = m_el[i] && m_en[i] && a_v[i] && !m_prev[i] && (m_pol[i] == m_pol_prev[i]);
        take    = (m_st[i] == M_PEND) && claim[i] && !chg[i];
        dec     = take && m_el[i] && (m_cnt[i] > 0);
        old_cnt = m_cnt[i];
        delta   = (edge_ev ? 1 : 0) - (dec ? 1 : 0);
        if (chg[i])                     m_cnt[i] = 0;
        else if (old_cnt + delta > MAXC) set_v[i] = 1'b1;
        else                            m_cnt[i] = old_cnt + delta;
        case (m_st[i])
          M_IDLE: if (!chg[i] && (m_el[i] ? old_cnt > 0 : (a_v[i] && m_en[i]))) m_st[i] = M_PEND;
          M_PEND: if (chg[i]) m_st[i] = M_IDLE; else if (claim[i]) m_st[i] = M_CLMD;
          default: if (complete[i]) m_st[i] = M_IDLE;
        endcase
      end
      m_ovf = (m_ovf & ~clr) | set_v;
      m_ready = valid;
      m_rdata = rd;
      m_prev = a_v; m_pol_prev = m_pol; m_pol = pol_n; m_el = el_n; m_en = en_n;
      for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = src;
    end
  end

  // ---------------- checking and drivers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("ip", ip, m_ip());
    check("ready", 64'(ready), 64'(m_ready));
    check("rdata", 64'(rdata), 64'(m_rdata));
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    step();
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    valid = 1'b1; address = a; wstrb = 4'h0;
    step();
    valid = 1'b0;
    check(tag, 64'(rdata), 64'(exp));
    check({tag, "_rdy"}, 64'(ready), 64'd1);
  endtask

  task automatic pulse(input int i);
    src[i] = 1'b1; step(); step();
    src[i] = 1'b0; step(); step();
  endtask

  task automatic do_claim(input int i);
    claim[i] = 1'b1; step(); claim[i] = 1'b0;
  endtask

  task automatic do_complete(input int i);
    complete[i] = 1'b1; step(); complete[i] = 1'b0;
  endtask

  function automatic logic [63:0] rmask(input int k);
    logic [63:0] r = '1;
    for (int j = 0; j < k; j++) r &= {$urandom, $urandom};
    return r;
  endfunction

  initial begin
    rst = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    src = '0; claim = '0; complete = '0;
    repeat (3) step();
    check("rst_ip", ip, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    rst = 1'b1;
    step();
    for (int k = 0; k < 10; k++) bus_rd("rst_reg", 16'(k*4), 32'h0);
    step();
    check("ready_drop", 64'(ready), 64'd0);

    // Edge source 3: latency, then claim/complete drains cnt 3 -> 0.
    bus_wr(16'h0010, 32'h0000_0008, 4'hF);
    bus_wr(16'h0000, 32'h0000_0008, 4'hF);
    src[3] = 1'b1; step(); step();
    src[3] = 1'b0; step();
    check("ip3_early", 64'(ip[3]), 64'd0);
    step();
    check("ip3_latency", 64'(ip[3]), 64'd1);
    pulse(3); pulse(3);
    for (int k = 0; k < 3; k++) begin
      do_claim(3);
      check("ip3_claimed", 64'(ip[3]), 64'd0);
      do_complete(3);
      step();
      check("ip3_rearm", 64'(ip[3]), (k < 2) ? 64'd1 : 64'd0);
    end

    // Edge source 5 saturation and OVF write-1-to-clear.
    bus_wr(16'h0010, 32'h0000_0028, 4'hF);
    bus_wr(16'h0000, 32'h0000_0028, 4'hF);
    for (int k = 0; k < 10; k++) pulse(5);
    bus_rd("ovf_set", 16'h0020, 32'h0000_0020);
    bus_wr(16'h0020, 32'h0000_0020, 4'hF);
    bus_rd("ovf_clr", 16'h0020, 32'h0000_0000);
    for (int k = 0; k < 8; k++) begin
      do_claim(5); do_complete(5); step();
      check("ip5_drain", 64'(ip[5]), (k < 7) ? 64'd1 : 64'd0);
    end

    // Level source 40, active-low.
    bus_wr(16'h000C, 32'h0000_0100, 4'hF);
    bus_wr(16'h0014, 32'h0000_0100, 4'hF);
    step();
    check("ip40_level", 64'(ip[40]), 64'd1);
    src[40] = 1'b1;
    repeat (4) step();
    check("ip40_hold", 64'(ip[40]), 64'd1);
    bus_rd("ip_mirror", 16'h001C, 32'h0000_0100);
    do_claim(40); do_complete(40); step(); step();
    check("ip40_done", 64'(ip[40]), 64'd0);

    // Edge source 7: claim coincides with a new edge.
    bus_wr(16'h0010, 32'h0000_00A8, 4'hF);
    bus_wr(16'h0000, 32'h0000_00A8, 4'hF);
    pulse(7);
    src[7] = 1'b1; step(); step();
    claim[7] = 1'b1; step(); claim[7] = 1'b0;
    check("ip7_claimed", 64'(ip[7]), 64'd0);
    src[7] = 1'b0;
    do_complete(7); step();
    check("ip7_repend", 64'(ip[7]), 64'd1);
    do_claim(7); do_complete(7); step();

    // Source 2: byte-strobed EL write flips it to level while pending.
    bus_wr(16'h0010, 32'h0000_00AC, 4'hF);
    bus_wr(16'h0000, 32'h1234_56AC, 4'hF);
    pulse(2);
    check("ip2_pend", 64'(ip[2]), 64'd1);
    bus_wr(16'h0000, 32'hFFFF_FFA8, 4'h1);
    check("ip2_elchg", 64'(ip[2]), 64'd0);
    bus_rd("el_strobe", 16'h0000, 32'h1234_56A8);
    do_claim(2); step();
    check("ip2_claim_idle", 64'(ip[2]), 64'd0);
    bus_rd("unmapped", 16'h0040, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      src      = src ^ rmask(3);
      claim    = rmask(3);
      complete = rmask(3);
      if ($urandom_range(0, 2) == 0) begin
        valid   = 1'b1;
        address = ($urandom_range(0, 15) == 0) ? 16'(16'h0028 + $urandom_range(0, 40) * 4)
                                               : 16'($urandom_range(0, 9) * 4);
        wstrb   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        wdata   = $urandom;
      end else begin
        valid = 1'b0; wstrb = 4'h0;
      end
      rst = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1; valid = 1'b0; claim = '0; complete = '0;
    step();

    // Reset while a request is presented: no ready follows.
    valid = 1'b1; address = 16'h0000; wstrb = 4'h0; rst = 1'b0;
    step();
    check("rst_mid_rdy", 64'(ready), 64'd0);
    check("rst_mid_ip", ip, 64'd0);
    valid = 1'b0; rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
